dwnstrm_accum: RTL
==================

# dwnstrm_accum

Parametrised downstream order processor: accepts a stream of (client_id, amount) cancellation events and keeps a per-client running total of cancelled orders in on-chip memory. Each accepted event performs a pipelined read-modify-write on that client's entry and reports the updated total together with a memory-write strobe. It replaces the fixed 32-client / 16-bit downstream stage. It adds input back-pressure, a clear operation, hazard forwarding, a power-up memory sweep and overflow handling.

## Interface
- NUM_CLIENTS, 32: number of client entries (≥2).
- CID_W, $clog2(NUM_CLIENTS): client_id width.
- AMT_W, 16: amount width; must be ≤ ACC_W.
- ACC_W, 16: accumulator / cancelled_orders width.

- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  event present.
- in_ready  out  1  block can accept; an event is accepted on a cycle with in_valid && in_ready.
- client_id  in  CID_W  target entry; values ≥ NUM_CLIENTS are dropped (accepted, no write, no output).
- amount  in  AMT_W  cancelled quantity, zero-extended to ACC_W.
- in_clear  in  1  1 = reset the entry to 0 instead of adding.
- out_valid  out  1  one-cycle result strobe; no output back-pressure.
- out_client_id  out  CID_W  entry just updated.
- cancelled_orders  out  ACC_W  new total, or the pre-clear total for a clear.
- memwr  out  1  entry committed; asserted exactly when out_valid is asserted.
- overflow  out  1  qualified by out_valid; see Configuration.

## Operation
- FSM states: ST_INIT and ST_RUN.
  - Reset enters ST_INIT with sweep counter = 0.
  - ST_INIT writes 0 to entry[counter] each cycle; in_ready = 0.
  - After entry NUM_CLIENTS−1 is written, the next cycle enters ST_RUN.
  - ST_RUN holds in_ready = 1 permanently until the next reset.
- Pipeline stages:
  - S0 (accept cycle): RAM read issued at client_id.
  - S1: read data is available. The operand is selected and the sum computed.
  - S2 register: the S1 result is written to the RAM and presented on the outputs.
- RAM behaviour: RAM is read-first. A read and a write to the same address on the same edge return the old data.
- Forwarding: if S1 and S2 are both valid with equal client ids, the S1 operand is the S2 result, not the RAM data. This single path covers all back-to-back same-client sequences.
- Add: result = operand + zext(amount).
- Clear: the RAM entry is written with 0. cancelled_orders = operand (old total). overflow = 0.
- Dropped ids leave S1/S2 valid low and are never forwarded.

## Timing
- Reset values: in_ready 0, out_valid 0, memwr 0, overflow 0, cancelled_orders 0, out_client_id 0. Pipeline valids and FSM return to ST_INIT asynchronously.
- First acceptance: the earliest accept is NUM_CLIENTS+1 cycles after rst falls. The first edge writes entry 0.
- Latency: an event accepted in cycle N produces out_valid/memwr in cycle N+2. The RAM contents reflect it from the edge ending cycle N+1.
- Throughput: one event per cycle, including identical client_id on consecutive cycles.
- Reset mid-operation: in-flight events are discarded with no output, and the sweep restarts at entry 0.
- Simultaneous clear and pending add on the same client: the order of acceptance is honoured. An add accepted after a clear sees 0.

## Configuration
- DWNSTRM_SAT_EN defined:
  - An add whose true sum exceeds 2^ACC_W−1 returns 2^ACC_W−1.
  - The stored entry is also 2^ACC_W−1.
  - overflow = 1.
- DWNSTRM_SAT_EN undefined:
  - The sum wraps modulo 2^ACC_W and is stored wrapped.
  - overflow = carry-out of the ACC_W add.

## Structure
- dwnstrm_pkg:
  - state enum type (ST_INIT, ST_RUN);
  - default parameter constants;
  - result struct (client id, total, overflow) shared with the bench monitor.
- Sub-module dwnstrm_acc_ram:
  - simple dual-port, synchronous read-first;
  - NUM_CLIENTS × ACC_W;
  - no contents reset (the sweep covers clearing).
- FSM, sweep counter, S1/S2 registers, forwarding mux and adder live in dwnstrm_accum.

## Test plan
- Reset then idle: in_ready stays 0 for 32 cycles, rises on cycle 33; a read-back of all ids via amount=0 returns 0 for every entry.
- Single add: id 3, amount 100, then id 3, amount 23 two cycles apart → outputs 100 then 123, each 2 cycles after accept, memwr with each.
- Back-to-back hazard: id 7, amounts 1, 2, 3 on consecutive cycles → outputs 1, 3, 6 on consecutive cycles.
- Clear: id 7 total 6, then clear, then add 5 back-to-back → outputs 6 (clear, overflow 0) then 5.
- Overflow: id 0 set to 65530, add 10 → with DWNSTRM_SAT_EN 65535, overflow 1, next add 0 returns 65535; without the macro 4, overflow 1, next add 0 returns 4.
- Mid-stream reset: assert rst one cycle after accepting id 2 amount 9 → no out_valid, sweep restarts; a later read of id 2 returns 0.

Source files
------------

// File: rtl/dwnstrm_pkg.sv
// dwnstrm_pkg: shared FSM state type, default sizes and result record for the downstream accumulator
package dwnstrm_pkg;
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  localparam int DEF_NUM_CLIENTS = 32;
  localparam int DEF_CID_W = $clog2(DEF_NUM_CLIENTS);
  localparam int DEF_AMT_W = 16;
  localparam int DEF_ACC_W = 16;
  typedef struct packed {
    logic [DEF_CID_W-1:0] cid;
    logic [DEF_ACC_W-1:0] total;
    logic                 ovf;
  } result_t;
endpackage

// File: rtl/dwnstrm_acc_ram.sv
// dwnstrm_acc_ram: simple dual-port read-first RAM holding one running total per client
// Ports: clk; we/waddr/wdata write port; raddr in, rdata out one cycle later (old data on same-edge write).
// Contents are not reset; the owner sweeps them to zero after reset.
module dwnstrm_acc_ram import dwnstrm_pkg::*; #(
  parameter int DEPTH = DEF_NUM_CLIENTS,
  parameter int AW = $clog2(DEPTH),
  parameter int W = DEF_ACC_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/dwnstrm_accum.sv
// dwnstrm_accum: per-client cancelled-order totals with a pipelined read-modify-write per event
// Ports: clk, rst (async, active high); in_valid/in_ready/client_id/amount/in_clear event input;
// out_valid/out_client_id/cancelled_orders/memwr/overflow result strobe two cycles after accept.
// Build option: define DWNSTRM_SAT_EN to saturate totals at all-ones instead of wrapping.
module dwnstrm_accum import dwnstrm_pkg::*; #(
  parameter int NUM_CLIENTS = DEF_NUM_CLIENTS,
  parameter int CID_W = $clog2(NUM_CLIENTS),
  parameter int AMT_W = DEF_AMT_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CID_W-1:0] client_id,
  input  logic [AMT_W-1:0] amount,
  input  logic             in_clear,
  output logic             out_valid,
  output logic [CID_W-1:0] out_client_id,
  output logic [ACC_W-1:0] cancelled_orders,
  output logic             memwr,
  output logic             overflow
);
  localparam logic [CID_W-1:0] LAST = CID_W'(NUM_CLIENTS - 1);
  localparam logic [CID_W:0] NCW = (CID_W + 1)'(NUM_CLIENTS);
  state_t state, nstate;
  logic [CID_W-1:0] cnt, s1_id, waddr;
  logic [AMT_W-1:0] s1_amt;
  logic s1_valid, s1_clr, we;
  logic [ACC_W-1:0] rdata, s2_wval, opnd, add_val, res_wval, res_out, wdata;
  logic [ACC_W:0] sum;
  logic accept;
  assign accept = in_valid && in_ready && ({1'b0, client_id} < NCW);
  assign memwr = out_valid;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
      cnt <= '0;
      s1_valid <= 1'b0;
      s1_id <= '0;
      s1_amt <= '0;
      s1_clr <= 1'b0;
      out_valid <= 1'b0;
      out_client_id <= '0;
      cancelled_orders <= '0;
      overflow <= 1'b0;
      s2_wval <= '0;
    end else begin
      state <= nstate;
      cnt <= (state == ST_INIT) ? cnt + 1'b1 : '0;
      s1_valid <= accept;
      s1_id <= client_id;
      s1_amt <= amount;
      s1_clr <= in_clear;
      out_valid <= s1_valid;
      out_client_id <= s1_id;
      cancelled_orders <= res_out;
      overflow <= s1_valid && !s1_clr && sum[ACC_W];
      s2_wval <= res_wval;
    end
  end
  // The RAM write port is owned by the zeroing sweep until the FSM reaches ST_RUN
  always_comb begin
    in_ready = state == ST_RUN;
    nstate = (state == ST_INIT && cnt == LAST) ? ST_RUN : state;
    we = in_ready ? s1_valid : 1'b1;
    waddr = in_ready ? s1_id : cnt;
    wdata = in_ready ? res_wval : '0;
  end
  // S2 holds the value just written; it overrides the stale read of a back-to-back same-client event
  always_comb begin
    opnd = (out_valid && out_client_id == s1_id) ? s2_wval : rdata;
    sum = {1'b0, opnd} + {{(ACC_W - AMT_W + 1){1'b0}}, s1_amt};
`ifdef DWNSTRM_SAT_EN
    add_val = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
    add_val = sum[ACC_W-1:0];
`endif
    res_wval = s1_clr ? '0 : add_val;
    res_out = s1_clr ? opnd : add_val;
  end
  dwnstrm_acc_ram #(.DEPTH(NUM_CLIENTS), .AW(CID_W), .W(ACC_W)) u_ram (
    .clk(clk),
    .we(we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(client_id),
    .rdata(rdata)
  );
endmodule
